// File: rtl/muldiv_div_sched_if.sv
// Request/response channel bundle between the muldiv front-end requesters
// and the shared-divider scheduler. The master side is the requester
// array and the slave side is the scheduler.
interface muldiv_div_sched_if #(
    parameter int NUM_REQS  = 4,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
);
    // Request channel, one lane per requester, packed lane i at [i*W +: W]
    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS-1:0]           req_ready;
    logic [NUM_REQS-1:0]           req_signed;
    logic [NUM_REQS-1:0]           req_rem;
    logic [NUM_REQS*XLEN-1:0]      req_numer;
    logic [NUM_REQS*XLEN-1:0]      req_denom;
    logic [NUM_REQS*TAG_WIDTH-1:0] req_tag;

    // Response channel, shared result/tag qualified by a one-hot valid
    logic [NUM_REQS-1:0]           rsp_valid;
    logic [NUM_REQS-1:0]           rsp_ready;
    logic [XLEN-1:0]               rsp_result;
    logic [TAG_WIDTH-1:0]          rsp_tag;

    modport master (
        output req_valid, req_signed, req_rem, req_numer, req_denom, req_tag,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  req_valid, req_signed, req_rem, req_numer, req_denom, req_tag,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/muldiv_div_sched.sv
// Round-robin scheduler sharing one iterative serial divider among
// NUM_REQS requesters. One division is in flight at a time:
// grant -> one-cycle launch strobe -> wait for busy to fall -> respond.
//
// Optional feature macro: MULDIV_SCHED_FASTPATH_EN
//   When defined, divide-by-zero and signed overflow (INT_MIN / -1) are
//   resolved at grant time without launching the divider, and the
//   response appears one cycle after the grant.
module muldiv_div_sched #(
    parameter int NUM_REQS  = 4,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_div_sched_if.slave    bus,
    output logic                 div_strobe,
    output logic                 div_signed,
    output logic [XLEN-1:0]      div_numer,
    output logic [XLEN-1:0]      div_denom,
    input  logic                 div_busy,
    input  logic [XLEN-1:0]      div_quotient,
    input  logic [XLEN-1:0]      div_remainder,
    output logic                 sched_busy
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RSP
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx_q;
    logic                 rem_q;
    logic                 wait_seen;
    logic [NUM_REQS-1:0]  rsp_valid_q;
    logic [XLEN-1:0]      rsp_result_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;

    // Unpacked views of the packed request lanes
    logic [XLEN-1:0]      numer_arr [NUM_REQS];
    logic [XLEN-1:0]      denom_arr [NUM_REQS];
    logic [TAG_WIDTH-1:0] tag_arr   [NUM_REQS];

    // Arbitration result for the current cycle
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [NUM_REQS-1:0]  grant_onehot;

    // Operands of the granted requester
    logic                 g_signed;
    logic                 g_rem;
    logic [XLEN-1:0]      g_numer;
    logic [XLEN-1:0]      g_denom;
    logic [TAG_WIDTH-1:0] g_tag;

    // Index arithmetic modulo NUM_REQS, valid for any NUM_REQS (not only 2^n)
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQS) begin
            sum = sum - NUM_REQS;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Split the packed operand buses into per-requester lanes
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            numer_arr[i] = bus.req_numer[i*XLEN +: XLEN];
            denom_arr[i] = bus.req_denom[i*XLEN +: XLEN];
            tag_arr[i]   = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, with wrap
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand_idx = wrap_add(rr_ptr, k);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_onehot = NUM_REQS'(1) << grant_idx;

    assign g_signed = bus.req_signed[grant_idx];
    assign g_rem    = bus.req_rem[grant_idx];
    assign g_numer  = numer_arr[grant_idx];
    assign g_denom  = denom_arr[grant_idx];
    assign g_tag    = tag_arr[grant_idx];

    // Accept is combinational in IDLE only; held off while reset is asserted
    // so that every output reads zero during reset.
    assign bus.req_ready = (state == IDLE && reset && grant_found) ? grant_onehot
                                                                   : '0;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_tag    = rsp_tag_q;

`ifdef MULDIV_SCHED_FASTPATH_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            fast_div0;
    logic            fast_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] fast_result;

    // Architecturally defined results for the cases the divider need not run
    always_comb begin
        fast_div0   = (g_denom == '0);
        fast_ovf    = g_signed && (g_numer == INT_MIN) && (g_denom == '1);
        fast_hit    = fast_div0 || fast_ovf;
        fast_result = '0;
        if (fast_div0) begin
            fast_result = g_rem ? g_numer : '1;
        end else if (fast_ovf) begin
            fast_result = g_rem ? '0 : g_numer;
        end
    end
`endif

    // Scheduler FSM with registered launch, response and busy outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the datapath latches are cleared along with the control
            // state because they drive ports that must read zero in reset.
            state        <= IDLE;
            rr_ptr       <= '0;
            idx_q        <= '0;
            rem_q        <= 1'b0;
            wait_seen    <= 1'b0;
            div_strobe   <= 1'b0;
            div_signed   <= 1'b0;
            div_numer    <= '0;
            div_denom    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            sched_busy   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge value of every other one.
            div_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        idx_q      <= grant_idx;
                        rem_q      <= g_rem;
                        div_signed <= g_signed;
                        div_numer  <= g_numer;
                        div_denom  <= g_denom;
                        rsp_tag_q  <= g_tag;
                        sched_busy <= 1'b1;
`ifdef MULDIV_SCHED_FASTPATH_EN
                        if (fast_hit) begin
                            rsp_result_q <= fast_result;
                            rsp_valid_q  <= grant_onehot;
                            state        <= RSP;
                        end else begin
                            div_strobe <= 1'b1;
                            state      <= START;
                        end
`else
                        div_strobe <= 1'b1;
                        state      <= START;
`endif
                    end
                end
                START: begin
                    wait_seen <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // The first WAIT cycle is skipped so busy may rise late
                    if (!wait_seen) begin
                        wait_seen <= 1'b1;
                    end else if (!div_busy) begin
                        rsp_result_q <= rem_q ? div_remainder : div_quotient;
                        rsp_valid_q  <= NUM_REQS'(1) << idx_q;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready[idx_q]) begin
                        rsp_valid_q <= '0;
                        sched_busy  <= 1'b0;
                        rr_ptr      <= wrap_add(idx_q, 1);
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requesters only see an accept for a lane they are actively requesting
    a_ready_implies_valid: assert property (
        @(posedge clk) disable iff (!reset)
        (bus.req_ready & ~bus.req_valid) == '0
    );

    // At most one response lane is ever active
    a_rsp_onehot0: assert property (
        @(posedge clk) disable iff (!reset)
        $onehot0(bus.rsp_valid)
    );

endmodule

// File: tb/tb_muldiv_div_sched.sv
// Directed bench for muldiv_div_sched: a table of single-request vectors
// plus hand-sequenced round-robin, back-pressure and mid-operation reset.
// A behavioural divider holds busy high for D cycles after each strobe.
module tb_muldiv_div_sched;

    localparam int NR = 4;
    localparam int XL = 32;
    localparam int TW = 8;
    localparam int D  = 4;

`ifdef MULDIV_SCHED_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          div_strobe;
    logic          div_signed;
    logic [XL-1:0] div_numer;
    logic [XL-1:0] div_denom;
    logic          div_busy;
    logic [XL-1:0] div_quotient;
    logic [XL-1:0] div_remainder;
    logic          sched_busy;

    muldiv_div_sched_if #(.NUM_REQS(NR), .XLEN(XL), .TAG_WIDTH(TW)) bus ();

    muldiv_div_sched #(.NUM_REQS(NR), .XLEN(XL), .TAG_WIDTH(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .div_strobe    (div_strobe),
        .div_signed    (div_signed),
        .div_numer     (div_numer),
        .div_denom     (div_denom),
        .div_busy      (div_busy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .sched_busy    (sched_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int strobe_cnt = 0;
    int busy_cnt   = 0;

    // Reference division with RISC-V semantics for the special cases
    function automatic logic [63:0] ref_div(input logic sgn,
                                            input logic [31:0] n,
                                            input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
        end else if (sgn && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = n;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end else begin
            q = n / d;
            r = n % d;
        end
        return {q, r};
    endfunction

    // Serial divider model: busy for D cycles starting the cycle after strobe
    always @(posedge clk) begin
        if (!reset) begin
            div_busy      <= 1'b0;
            busy_cnt      <= 0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_strobe) begin
            div_busy   <= 1'b1;
            busy_cnt   <= D;
            strobe_cnt <= strobe_cnt + 1;
            {div_quotient, div_remainder} <= ref_div(div_signed, div_numer, div_denom);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            div_busy <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int rid, input logic sgn, input logic rem,
                           input logic [31:0] n, input logic [31:0] d,
                           input logic [7:0] tag);
        bus.req_signed[rid]         = sgn;
        bus.req_rem[rid]            = rem;
        bus.req_numer[rid*XL +: XL] = n;
        bus.req_denom[rid*XL +: XL] = d;
        bus.req_tag[rid*TW +: TW]   = tag;
    endtask

    typedef struct {
        int          rid;
        logic        sgn;
        logic        rem;
        logic [31:0] n;
        logic [31:0] d;
        logic [7:0]  tag;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs [11];

    // One request on a single lane, from grant to response acceptance
    task automatic run_vec(input int idx, input vec_t v);
        logic          fast;
        int            lat;
        int            s0;
        logic [NR-1:0] oh;
        fast = FAST && v.special;
        oh   = NR'(1) << v.rid;
        s0   = strobe_cnt;
        set_req(v.rid, v.sgn, v.rem, v.n, v.d, v.tag);
        bus.rsp_ready = '1;
        bus.req_valid = oh;
        settle();
        check($sformatf("v%0d_req_ready", idx), bus.req_ready, oh);
        tick();
        bus.req_valid = '0;
        settle();
        check($sformatf("v%0d_strobe", idx), div_strobe, !fast);
        check($sformatf("v%0d_div_numer", idx), div_numer, v.n);
        check($sformatf("v%0d_div_denom", idx), div_denom, v.d);
        lat = 1;
        while (bus.rsp_valid == '0 && lat < 60) begin
            tick();
            settle();
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, fast ? 1 : D + 3);
        check($sformatf("v%0d_rsp_valid", idx), bus.rsp_valid, oh);
        check($sformatf("v%0d_result", idx), bus.rsp_result, v.exp);
        check($sformatf("v%0d_tag", idx), bus.rsp_tag, v.tag);
        check($sformatf("v%0d_strobes", idx), strobe_cnt - s0, fast ? 0 : 1);
        tick();
        settle();
        check($sformatf("v%0d_idle", idx), sched_busy, 1'b0);
    endtask

    int rr_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int waited;
        int last_g;

        reset          = 1'b0;
        bus.req_valid  = '0;
        bus.req_signed = '0;
        bus.req_rem    = '0;
        bus.req_numer  = '0;
        bus.req_denom  = '0;
        bus.req_tag    = '0;
        bus.rsp_ready  = '1;

        //          rid sgn   rem   numer          denom          tag    expected       special
        vecs[0]  = '{0, 1'b0, 1'b0, 32'd100,       32'd7,         8'h11, 32'd14,        1'b0};
        vecs[1]  = '{1, 1'b0, 1'b1, 32'd100,       32'd7,         8'h22, 32'd2,         1'b0};
        vecs[2]  = '{2, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         8'h33, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         8'h44, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{1, 1'b0, 1'b0, 32'd5,         32'd0,         8'h55, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2, 1'b0, 1'b1, 32'd5,         32'd0,         8'h66, 32'd5,         1'b1};
        vecs[6]  = '{0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h77, 32'd0,         1'b1};
        vecs[7]  = '{3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h88, 32'h8000_0000, 1'b1};
        vecs[8]  = '{0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h99, 32'd0,         1'b0};
        vecs[9]  = '{2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         8'hAA, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7,         8'hBB, 32'hFFFF_FFF2, 1'b0};

        // Reset state, with every lane requesting to show accept is held off
        tick();
        tick();
        bus.req_valid = '1;
        settle();
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_strobe", div_strobe, 1'b0);
        check("rst_div_numer", div_numer, '0);
        check("rst_rsp_result", bus.rsp_result, '0);
        check("rst_rsp_tag", bus.rsp_tag, '0);
        check("rst_sched_busy", sched_busy, 1'b0);
        bus.req_valid = '0;
        reset = 1'b1;
        tick();
        settle();

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted while the scheduler is in WAIT
        set_req(2, 1'b0, 1'b0, 32'd1000, 32'd10, 8'h5A);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        settle();
        check("mid_rst_busy_before", sched_busy, 1'b1);
        reset         = 1'b0;
        bus.req_valid = '1;
        tick();
        settle();
        check("mid_rst_req_ready", bus.req_ready, '0);
        check("mid_rst_rsp_valid", bus.rsp_valid, '0);
        check("mid_rst_strobe", div_strobe, 1'b0);
        check("mid_rst_div_signed", div_signed, 1'b0);
        check("mid_rst_div_numer", div_numer, '0);
        check("mid_rst_div_denom", div_denom, '0);
        check("mid_rst_rsp_result", bus.rsp_result, '0);
        check("mid_rst_rsp_tag", bus.rsp_tag, '0);
        check("mid_rst_sched_busy", sched_busy, 1'b0);

        // Release with all lanes valid: round-robin from lane 0 at full rate
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, 1'b0, 32'd64 + 32'(i), 32'd8, 8'hE0 + 8'(i));
        end
        reset  = 1'b1;
        last_g = 0;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            settle();
            while (bus.req_ready == '0 && waited < 40) begin
                tick();
                settle();
                waited++;
            end
            check($sformatf("rr_grant%0d", g), bus.req_ready, NR'(1) << rr_order[g]);
            if (g > 0) begin
                check($sformatf("rr_interval%0d", g), cyc - last_g, D + 4);
            end
            last_g = cyc;
            tick();
        end
        bus.req_valid = '0;
        waited = 0;
        settle();
        while (sched_busy && waited < 60) begin
            tick();
            settle();
            waited++;
        end
        check("rr_drain", sched_busy, 1'b0);

        // Back-pressure on lane 2; other lanes' rsp_ready must not release it
        set_req(2, 1'b0, 1'b0, 32'd1000, 32'd10, 8'hC3);
        bus.rsp_ready = 4'b1011;
        bus.req_valid = 4'b0100;
        settle();
        check("bp_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1001;
        waited = 0;
        settle();
        while (bus.rsp_valid == '0 && waited < 40) begin
            tick();
            settle();
            waited++;
        end
        check("bp_rsp_valid", bus.rsp_valid, 4'b0100);
        check("bp_result", bus.rsp_result, 32'd100);
        check("bp_tag", bus.rsp_tag, 8'hC3);
        for (int k = 0; k < 5; k++) begin
            tick();
            settle();
            check($sformatf("bp_hold_valid%0d", k), bus.rsp_valid, 4'b0100);
            check($sformatf("bp_hold_result%0d", k), bus.rsp_result, 32'd100);
            check($sformatf("bp_hold_tag%0d", k), bus.rsp_tag, 8'hC3);
            check($sformatf("bp_hold_ready%0d", k), bus.req_ready, '0);
        end
        bus.rsp_ready = '1;
        tick();
        settle();
        check("bp_next_grant", bus.req_ready, 4'b1000);
        check("bp_rsp_cleared", bus.rsp_valid, '0);
        tick();
        bus.req_valid = '0;
        waited = 0;
        settle();
        while (sched_busy && waited < 60) begin
            tick();
            settle();
            waited++;
        end
        check("bp_drain", sched_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_div_sched.md
Name: muldiv_div_sched

Overview:
- Round-robin scheduler that shares one iterative serial divider among NUM_REQS requesters, e.g. the issue slots of several ALU muldiv lanes.
- Per request it performs four steps: grant, launch the divider with a one-cycle strobe, wait on busy, then return the result and tag on the granted requester's response channel.
- One division is in flight at a time.
- Sits between the execute-side muldiv front end and the shared serial divider datapath.

Parameters:
- NUM_REQS, 4, number of requesters (≥2).
- XLEN, 32, operand and result width.
- TAG_WIDTH, 8, opaque per-request tag returned unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQS  request valid per requester
- req_ready  out  NUM_REQS  request accepted (one-hot or zero)
- req_signed  in  NUM_REQS  signed division
- req_rem  in  NUM_REQS  return remainder (1) or quotient (0)
- req_numer  in  NUM_REQS*XLEN  numerators, requester i at [i*XLEN +: XLEN]
- req_denom  in  NUM_REQS*XLEN  denominators, same packing
- req_tag  in  NUM_REQS*TAG_WIDTH  tags, same packing
- rsp_valid  out  NUM_REQS  response valid, at most one bit set
- rsp_ready  in  NUM_REQS  response accept per requester
- rsp_result  out  XLEN  result for the requester whose rsp_valid is set
- rsp_tag  out  TAG_WIDTH  tag of that request
- div_strobe  out  1  one-cycle launch pulse to the divider
- div_signed  out  1  latched signedness
- div_numer  out  XLEN  latched numerator
- div_denom  out  XLEN  latched denominator
- div_busy  in  1  divider busy; rises the cycle after strobe, falls when the result is valid
- div_quotient  in  XLEN  divider quotient
- div_remainder  in  XLEN  divider remainder
- sched_busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr_ptr=0, wait_seen=0.
  - All outputs 0: req_ready, rsp_valid, div_strobe, div_*, rsp_result, rsp_tag, sched_busy.
  - Applies mid-operation; any in-flight result is dropped. The divider is reset separately.
- States: IDLE, START, WAIT, RSP.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[i] is combinationally 1 for the granted i only.
  - On grant, latch signed, rem, numer, denom, tag and index; next state START.
  - No valid request: stay in IDLE with req_ready=0.
- START: div_strobe=1 for exactly one cycle; wait_seen cleared; next state WAIT.
- WAIT:
  - The first WAIT cycle is always ignored (sets wait_seen), so a late-rising busy is tolerated.
  - On a cycle with wait_seen==1 && div_busy==0: capture quotient or remainder per rem into the result register; next state RSP.
- RSP:
  - rsp_valid[idx]=1; rsp_result and rsp_tag are held stable.
  - Stays in RSP until rsp_ready[idx]==1.
  - On that cycle: state→IDLE and rr_ptr←(idx+1) mod NUM_REQS. A new grant is possible on the following cycle, not the same one.
  - rsp_ready bits of other requesters are ignored.
- Latency: with divider busy high for D cycles, a grant in cycle 0 gives rsp_valid in cycle D+3. Minimum issue interval is D+4 cycles with rsp_ready tied high.
- Simultaneous events:
  - req_valid seen in RSP is not granted until IDLE.
  - A requester dropping req_valid while not granted is legal.
  - req_valid must not drop after req_ready was given (protocol assertion).
- div_busy high while IDLE/START is ignored.
- Fairness: every continuously asserting requester is served within NUM_REQS grants.

Optional Feature:
- Macro: MULDIV_SCHED_FASTPATH_EN.
- Defined: special cases resolve in IDLE at grant, with no div_strobe; next state is RSP directly, so rsp_valid appears in cycle 1.
  - denom==0: quotient = all-ones, remainder = numer.
  - req_signed && numer==2^(XLEN-1) && denom==all-ones: quotient = numer, remainder = 0.
- Undefined: all requests go through START/WAIT and results come from the divider unchanged.

Test Plan:
- Single request, requester 0, unsigned 100/7, quotient; divider model D=4 → req_ready[0] in cycle 0, div_strobe in cycle 1, rsp_valid[0] in cycle 7, rsp_result=14, rsp_tag echoed.
- All 4 requesters continuously valid, rsp_ready=1 → grant order 0,1,2,3,0,1; each req_ready one-hot; no two div_strobe pulses closer than D+4 cycles.
- rsp_ready[2] held 0 for 5 cycles during RSP → rsp_valid[2], rsp_result and rsp_tag stable; req_ready=0 throughout; next grant goes to requester 3.
- Signed remainder -7 % 2 (0xFFFFFFF9, 0x2, rem=1) → rsp_result=0xFFFFFFFF; signed quotient gives 0xFFFFFFFD.
- With MULDIV_SCHED_FASTPATH_EN:
  - 5/0 quotient → 0xFFFFFFFF in cycle 1, no div_strobe.
  - 0x80000000 / 0xFFFFFFFF signed remainder → 0x00000000.
  - Without the macro, the same cases pulse div_strobe.
- reset=0 asserted during WAIT → next cycle all outputs 0, state IDLE; after release, the lowest-index valid requester (rr_ptr=0) is granted first.
